// File: rtl/bp_stream_pkg.sv
// Shared types and default address map for the host stream router.
// The ibuf kind enum and address constants are re-used by the top and the arbiter.
package bp_stream_pkg;

   // What the buffered inbound word is destined for.
   typedef enum logic [1:0] {
      e_chan   = 2'd0,
      e_status = 2'd1,
      e_drop   = 2'd2
   } ibuf_kind_e;

   // Default host address map.
   localparam logic [31:0] nbf_addr_gp    = 32'h10;
   localparam logic [31:0] mmio_addr_gp   = 32'h20;
   localparam logic [31:0] status_addr_gp = 32'hF0;
   localparam logic [31:0] chan_stride_gp = mmio_addr_gp - nbf_addr_gp;

   // Index width that stays legal for a single channel.
   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bp_stream_rr_arb.sv
// Round-robin arbiter over num_chan_p requesters.
// Grants only while en_i is high; the priority pointer moves to grant+1 only on a grant
// and starts at requester 0 after reset.
module bp_stream_rr_arb
   import bp_stream_pkg::*;
#(
   parameter  int num_chan_p = 2,
   localparam int idx_w_lp   = safe_clog2(num_chan_p)
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  en_i,
   input  logic [num_chan_p-1:0] req_i,
   output logic [num_chan_p-1:0] grant_o,
   output logic                  grant_v_o,
   output logic [idx_w_lp-1:0]   grant_idx_o
);

   localparam int sum_w_lp = idx_w_lp + 1;

   logic [idx_w_lp-1:0] ptr_r;
   logic [sum_w_lp-1:0] scan_sum;
   logic [idx_w_lp-1:0] scan_idx;
   logic                found;

   // Scan requesters starting at the pointer and pick the first one asserted.
   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      found       = 1'b0;
      grant_idx_o = '0;
      scan_sum    = '0;
      scan_idx    = '0;
      for (int k = 0; k < num_chan_p; k++) begin
         scan_sum = {1'b0, ptr_r} + sum_w_lp'(k);
         if (scan_sum >= sum_w_lp'(num_chan_p)) begin
            scan_sum = scan_sum - sum_w_lp'(num_chan_p);
         end
         scan_idx = scan_sum[idx_w_lp-1:0];
         if (!found && req_i[scan_idx]) begin
            found       = 1'b1;
            grant_idx_o = scan_idx;
         end
      end
      grant_v_o = en_i & found;
      grant_o   = '0;
      if (grant_v_o) begin
         grant_o[grant_idx_o] = 1'b1;
      end
   end

   // Advance the priority pointer past the winner whenever a grant is issued.
   // NOTE: clocked state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         ptr_r <= '0;
      end else if (grant_v_o) begin
         ptr_r <= (grant_idx_o == idx_w_lp'(num_chan_p - 1)) ? '0 : grant_idx_o + 1'b1;
      end
   end

endmodule

// File: rtl/bp_stream_host_router.sv
// Host-side stream router.
// Inbound: a one-entry buffer decodes each host word into a channel, a status read or a drop.
// Outbound: endpoint words are merged round-robin into a one-entry output register;
// status reads inject the saturating drop count into the same register.
module bp_stream_host_router
   import bp_stream_pkg::*;
#(
   parameter int                             num_chan_p          = 2,
   parameter int                             stream_addr_width_p = 32,
   parameter int                             stream_data_width_p = 32,
   parameter logic [stream_addr_width_p-1:0] base_addr_p         = stream_addr_width_p'(nbf_addr_gp),
   parameter logic [stream_addr_width_p-1:0] addr_stride_p       = stream_addr_width_p'(chan_stride_gp),
   parameter logic [stream_addr_width_p-1:0] status_addr_p       = stream_addr_width_p'(status_addr_gp),
   parameter int                             err_cnt_width_p     = 16
) (
   input  logic                                      clk_i,
   input  logic                                      reset_i,
   // host inbound
   input  logic                                      stream_v_i,
   input  logic [stream_addr_width_p-1:0]            stream_addr_i,
   input  logic [stream_data_width_p-1:0]            stream_data_i,
   output logic                                      stream_yumi_o,
   // endpoint inbound
   output logic [num_chan_p-1:0]                     chan_v_o,
   output logic [stream_data_width_p-1:0]            chan_data_o,
   input  logic [num_chan_p-1:0]                     chan_ready_i,
   // endpoint outbound
   input  logic [num_chan_p-1:0]                     chan_v_i,
   input  logic [num_chan_p*stream_data_width_p-1:0] chan_data_i,
   output logic [num_chan_p-1:0]                     chan_yumi_o,
   // host outbound
   output logic                                      stream_v_o,
   output logic [stream_data_width_p-1:0]            stream_data_o,
   input  logic                                      stream_ready_i,
   output logic                                      err_o
);

   localparam int chan_idx_w_lp = safe_clog2(num_chan_p);

   // Inbound buffer
   logic                           ibuf_full_r;
   ibuf_kind_e                     ibuf_kind_r;
   logic [chan_idx_w_lp-1:0]       ibuf_chan_r;
   logic [stream_data_width_p-1:0] ibuf_data_r;

   ibuf_kind_e                     dec_kind;
   logic [chan_idx_w_lp-1:0]       dec_chan;

   logic ibuf_is_chan, ibuf_is_drop, ibuf_is_status;
   logic ibuf_deq;

   // Outbound register and drop counter
   logic                           out_full_r;
   logic [stream_data_width_p-1:0] out_data_r;
   logic                           out_load_en;
   logic                           status_load;
   logic [err_cnt_width_p-1:0]     drop_cnt_r;
   logic                           err_r;

   // Arbiter interface
   logic                           arb_en;
   logic                           grant_v;
   logic [chan_idx_w_lp-1:0]       grant_idx;
   logic [stream_data_width_p-1:0] grant_data;

   // Decode the inbound address; the lowest matching channel wins, anything unmatched is dropped.
   always_comb begin
      dec_kind = (stream_addr_i == status_addr_p) ? e_status : e_drop;
      dec_chan = '0;
      for (int i = num_chan_p - 1; i >= 0; i--) begin
         if (stream_addr_i == base_addr_p + stream_addr_width_p'(i) * addr_stride_p) begin
            dec_kind = e_chan;
            dec_chan = chan_idx_w_lp'(i);
         end
      end
   end

   assign ibuf_is_chan   = ibuf_full_r & (ibuf_kind_r == e_chan);
   assign ibuf_is_drop   = ibuf_full_r & (ibuf_kind_r == e_drop);
   assign ibuf_is_status = ibuf_full_r & (ibuf_kind_r == e_status);

   // The output register takes a new word when empty or when its current word leaves this cycle.
   assign out_load_en = ~out_full_r | stream_ready_i;
   assign status_load = ibuf_is_status & out_load_en;

   assign ibuf_deq = (ibuf_is_chan & chan_ready_i[ibuf_chan_r])
                   | ibuf_is_drop
                   | status_load;

   // Accept when empty or draining; the buffer reloads in the same cycle it drains.
   assign stream_yumi_o = reset_i & stream_v_i & (~ibuf_full_r | ibuf_deq);

   // Track ibuf occupancy.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         ibuf_full_r <= 1'b0;
      end else if (stream_yumi_o) begin
         ibuf_full_r <= 1'b1;
      end else if (ibuf_deq) begin
         ibuf_full_r <= 1'b0;
      end
   end

   // Capture the decoded word into the ibuf payload.
   // NOTE: payload registers are not reset; they are only observed while their full flag is set.
   always_ff @(posedge clk_i) begin
      if (stream_yumi_o) begin
         ibuf_kind_r <= dec_kind;
         ibuf_chan_r <= dec_chan;
         ibuf_data_r <= stream_data_i;
      end
   end

   // Present a channel word on exactly one endpoint valid.
   always_comb begin
      chan_v_o = '0;
      if (reset_i && ibuf_is_chan) begin
         chan_v_o[ibuf_chan_r] = 1'b1;
      end
   end

   assign chan_data_o = ibuf_data_r;

   // Count drops with saturation; a status read clears the count as it is reported.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         drop_cnt_r <= '0;
         err_r      <= 1'b0;
      end else begin
         if (status_load) begin
            drop_cnt_r <= ibuf_is_drop ? err_cnt_width_p'(1) : '0;
         end else if (ibuf_is_drop && (drop_cnt_r != '1)) begin
            drop_cnt_r <= drop_cnt_r + 1'b1;
         end
         if (ibuf_is_drop) begin
            err_r <= 1'b1;
         end
      end
   end

   assign err_o = err_r;

   // A pending status read holds off channel grants so it is never starved.
   assign arb_en = reset_i & out_load_en & ~ibuf_is_status;

   bp_stream_rr_arb #(
      .num_chan_p (num_chan_p)
   ) u_arb (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .en_i        (arb_en),
      .req_i       (chan_v_i),
      .grant_o     (chan_yumi_o),
      .grant_v_o   (grant_v),
      .grant_idx_o (grant_idx)
   );

   // Select the granted endpoint's data slice.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < num_chan_p; i++) begin
         if (grant_idx == chan_idx_w_lp'(i)) begin
            grant_data = chan_data_i[i*stream_data_width_p +: stream_data_width_p];
         end
      end
   end

   // Track output register occupancy.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         out_full_r <= 1'b0;
      end else if (status_load || grant_v) begin
         out_full_r <= 1'b1;
      end else if (stream_ready_i) begin
         out_full_r <= 1'b0;
      end
   end

   // Load the output word: status count first, otherwise the granted endpoint's data.
   always_ff @(posedge clk_i) begin
      if (status_load) begin
         out_data_r <= stream_data_width_p'(drop_cnt_r);
      end else if (grant_v) begin
         out_data_r <= grant_data;
      end
   end

   assign stream_v_o    = out_full_r;
   assign stream_data_o = out_data_r;

endmodule

// File: tb/tb_bp_stream_host_router.sv
// Scoreboard bench for bp_stream_host_router: stimulus pushes expected words into queues,
// a negedge monitor pops and compares on every endpoint-side and host-side handshake.
module tb_bp_stream_host_router;

   localparam int N = 2;
   localparam int D = 32;

   logic           clk_i = 1'b0;
   logic           reset_i;
   logic           stream_v_i;
   logic [31:0]    stream_addr_i;
   logic [D-1:0]   stream_data_i;
   logic           stream_yumi_o;
   logic [N-1:0]   chan_v_o;
   logic [D-1:0]   chan_data_o;
   logic [N-1:0]   chan_ready_i;
   logic [N-1:0]   chan_v_i;
   logic [N*D-1:0] chan_data_i;
   logic [N-1:0]   chan_yumi_o;
   logic           stream_v_o;
   logic [D-1:0]   stream_data_o;
   logic           stream_ready_i;
   logic           err_o;

   bp_stream_host_router #(.num_chan_p(N)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .stream_v_i     (stream_v_i),
      .stream_addr_i  (stream_addr_i),
      .stream_data_i  (stream_data_i),
      .stream_yumi_o  (stream_yumi_o),
      .chan_v_o       (chan_v_o),
      .chan_data_o    (chan_data_o),
      .chan_ready_i   (chan_ready_i),
      .chan_v_i       (chan_v_i),
      .chan_data_i    (chan_data_i),
      .chan_yumi_o    (chan_yumi_o),
      .stream_v_o     (stream_v_o),
      .stream_data_o  (stream_data_o),
      .stream_ready_i (stream_ready_i),
      .err_o          (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          idx;
      logic [31:0] data;
   } chan_exp_t;

   chan_exp_t   chan_q[$];
   logic [31:0] out_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every completed handshake against the head of its queue.
   always @(negedge clk_i) begin
      if (reset_i === 1'b1) begin
         if (chan_v_o != '0) check("chan_v_onehot", 64'($onehot(chan_v_o)), 64'(1));
         for (int i = 0; i < N; i++) begin
            if (chan_v_o[i] && chan_ready_i[i]) begin
               check("chan_q_nonempty", 64'(chan_q.size() > 0), 64'(1));
               if (chan_q.size() > 0) begin
                  chan_exp_t e;
                  e = chan_q.pop_front();
                  check("chan_idx", 64'(i), 64'(e.idx));
                  check("chan_data", 64'(chan_data_o), 64'(e.data));
               end
            end
         end
         if (stream_v_o && stream_ready_i) begin
            check("out_q_nonempty", 64'(out_q.size() > 0), 64'(1));
            if (out_q.size() > 0) begin
               logic [31:0] e;
               e = out_q.pop_front();
               check("out_data", 64'(stream_data_o), 64'(e));
            end
         end
      end
   end

   // Watchdog: a hang ends the run with a visible failure.
   initial begin
      #1500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic send(input logic [31:0] a, input logic [31:0] d);
      int k;
      stream_v_i    = 1'b1;
      stream_addr_i = a;
      stream_data_i = d;
      for (k = 0; k < 200; k++) begin
         @(negedge clk_i);
         if (stream_yumi_o) break;
      end
      if (k >= 200) check("send_accepted", 64'(k < 200), 64'(1));
      @(posedge clk_i); #1;
      stream_v_i = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         if (chan_q.size() == 0 && out_q.size() == 0) break;
         @(posedge clk_i); #1;
      end
      check("queues_drained", 64'(chan_q.size() + out_q.size()), 64'(0));
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      reset_i = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stream_yumi"}, 64'(stream_yumi_o), 64'(0));
      check({tag, "_chan_v"},      64'(chan_v_o),      64'(0));
      check({tag, "_chan_yumi"},   64'(chan_yumi_o),   64'(0));
      check({tag, "_stream_v"},    64'(stream_v_o),    64'(0));
      check({tag, "_err"},         64'(err_o),         64'(0));
   endtask

   initial begin
      chan_exp_t   ce;
      int          sent [N];
      logic [1:0]  exp_g;
      logic [31:0] held;
      int          gi;

      // Reset with active inputs: combinational handshakes must stay gated.
      reset_i        = 1'b0;
      stream_v_i     = 1'b1;
      stream_addr_i  = 32'h10;
      stream_data_i  = '0;
      chan_ready_i   = 2'b11;
      chan_v_i       = 2'b11;
      chan_data_i    = '0;
      stream_ready_i = 1'b1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check_all_zero("reset");
      @(posedge clk_i); #1;
      stream_v_i = 1'b0;
      chan_v_i   = 2'b00;
      reset_i    = 1'b1;
      @(posedge clk_i); #1;

      // Two back-to-back channel writes.
      ce.idx = 0; ce.data = 32'hA5A5_0001; chan_q.push_back(ce);
      ce.idx = 1; ce.data = 32'hA5A5_0002; chan_q.push_back(ce);
      stream_v_i = 1'b1; stream_addr_i = 32'h10; stream_data_i = 32'hA5A5_0001;
      @(negedge clk_i);
      check("t1_yumi_first", 64'(stream_yumi_o), 64'(1));
      check("t1_chan_v_idle", 64'(chan_v_o), 64'(0));
      @(posedge clk_i); #1;
      stream_addr_i = 32'h20; stream_data_i = 32'hA5A5_0002;
      @(negedge clk_i);
      check("t1_yumi_second", 64'(stream_yumi_o), 64'(1));
      check("t1_chan_v_n1", 64'(chan_v_o), 64'(2'b01));
      @(posedge clk_i); #1;
      stream_v_i = 1'b0;
      @(negedge clk_i);
      check("t1_chan_v_n2", 64'(chan_v_o), 64'(2'b10));
      @(posedge clk_i); #1;
      drain();

      // Three drops then two status reads.
      out_q.push_back(32'd3);
      out_q.push_back(32'd0);
      send(32'h14, 32'h1);
      send(32'h14, 32'h2);
      send(32'h14, 32'h3);
      send(32'hF0, 32'h0);
      send(32'hF0, 32'h0);
      drain();
      check("t2_err_sticky", 64'(err_o), 64'(1));

      // Saturation of the drop counter.
      for (int i = 0; i < 65537; i++) send(32'h14, 32'(i));
      out_q.push_back(32'h0000_FFFF);
      send(32'hF0, 32'h0);
      drain();

      // Round-robin merge with a host stall.
      do_reset();
      out_q.push_back(32'hC000_0000); out_q.push_back(32'hC100_0000);
      out_q.push_back(32'hC000_0001); out_q.push_back(32'hC100_0001);
      out_q.push_back(32'hC000_0002); out_q.push_back(32'hC100_0002);
      out_q.push_back(32'hC000_0003); out_q.push_back(32'hC100_0003);
      sent[0] = 0; sent[1] = 0;
      exp_g = 2'b01;
      held  = '0;
      stream_ready_i = 1'b1;
      chan_ready_i   = 2'b00;
      chan_v_i       = 2'b11;
      chan_data_i    = {32'hC100_0000, 32'hC000_0000};
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk_i);
         if (cyc >= 5 && cyc < 10) begin
            check("t4_stall_no_yumi", 64'(chan_yumi_o), 64'(0));
            check("t4_stall_valid", 64'(stream_v_o), 64'(1));
            if (cyc == 5) held = stream_data_o;
            else check("t4_stall_data_stable", 64'(stream_data_o), 64'(held));
         end
         if (chan_yumi_o != '0) begin
            check("t4_grant_order", 64'(chan_yumi_o), 64'(exp_g));
            gi = chan_yumi_o[1] ? 1 : 0;
            sent[gi]++;
            exp_g = {exp_g[0], exp_g[1]};
         end
         @(posedge clk_i); #1;
         stream_ready_i = !(cyc >= 4 && cyc < 9);
         chan_v_i[0] = (sent[0] < 4);
         chan_v_i[1] = (sent[1] < 4);
         chan_data_i = {32'hC100_0000 + 32'(sent[1]), 32'hC000_0000 + 32'(sent[0])};
         if (sent[0] == 4 && sent[1] == 4 && out_q.size() == 0) break;
      end
      chan_v_i = 2'b00;
      check("t4_sent_ch0", 64'(sent[0]), 64'(4));
      check("t4_sent_ch1", 64'(sent[1]), 64'(4));
      drain();

      // Channel 0 stalls four cycles; the next word waits, then reloads on the drain.
      ce.idx = 0; ce.data = 32'h5555_0001; chan_q.push_back(ce);
      ce.idx = 1; ce.data = 32'h5555_0002; chan_q.push_back(ce);
      chan_ready_i = 2'b00;
      stream_v_i = 1'b1; stream_addr_i = 32'h10; stream_data_i = 32'h5555_0001;
      @(negedge clk_i);
      check("t5_yumi_first", 64'(stream_yumi_o), 64'(1));
      @(posedge clk_i); #1;
      stream_addr_i = 32'h20; stream_data_i = 32'h5555_0002;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         check("t5_blocked_yumi", 64'(stream_yumi_o), 64'(0));
         check("t5_blocked_chan_v", 64'(chan_v_o), 64'(2'b01));
         @(posedge clk_i); #1;
      end
      chan_ready_i = 2'b11;
      @(negedge clk_i);
      check("t5_reload_yumi", 64'(stream_yumi_o), 64'(1));
      @(posedge clk_i); #1;
      stream_v_i = 1'b0;
      @(negedge clk_i);
      check("t5_second_chan_v", 64'(chan_v_o), 64'(2'b10));
      @(posedge clk_i); #1;
      drain();

      // Reset with both buffers full.
      chan_ready_i   = 2'b00;
      stream_ready_i = 1'b0;
      send(32'h14, 32'h0);
      send(32'h10, 32'hDEAD_0001);
      chan_data_i = {32'h0, 32'hBEEF_0000};
      chan_v_i    = 2'b01;
      @(negedge clk_i);
      check("t6_fill_grant", 64'(chan_yumi_o), 64'(2'b01));
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("t6_out_full", 64'(stream_v_o), 64'(1));
      check("t6_ibuf_full", 64'(chan_v_o), 64'(2'b01));
      check("t6_host_stall_no_yumi", 64'(chan_yumi_o), 64'(0));
      check("t6_err_set", 64'(err_o), 64'(1));
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      stream_v_i = 1'b1; stream_addr_i = 32'h20;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check_all_zero("t6_reset");
      @(posedge clk_i); #1;
      reset_i        = 1'b1;
      stream_v_i     = 1'b0;
      chan_v_i       = 2'b00;
      chan_ready_i   = 2'b11;
      stream_ready_i = 1'b1;
      out_q.push_back(32'd0);
      send(32'hF0, 32'h0);
      drain();
      check("t6_err_cleared", 64'(err_o), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bp_stream_host_router.md
# bp_stream_host_router

Parametrised host-side stream router between the host AXI-Lite stream and N on-chip stream endpoints (NBF loader, MMIO, future debug channels). It decodes each inbound word's address into a channel through a one-entry input buffer, and drops and counts unmapped writes. It merges the endpoints' outbound words onto one host stream through a round-robin arbiter and a one-entry output register. A dedicated status address returns the drop count on the outbound stream.

## Interface
- num_chan_p, 2: number of endpoint channels (1..8).
- stream_addr_width_p, 32: host address width.
- stream_data_width_p, 32: data width, all streams.
- base_addr_p, 32'h10: address of channel 0.
- addr_stride_p, 32'h10: channel i address = base_addr_p + i*addr_stride_p.
- status_addr_p, 32'hF0: status-read address; must not alias any channel address.
- err_cnt_width_p, 16: drop-counter width; must be ≤ stream_data_width_p.
- clk_i  in  1  sole clock; all state on posedge.
- reset_i  in  1  synchronous, active-low reset, sampled on posedge clk_i.
- stream_v_i  in  1  inbound word valid.
- stream_addr_i  in  stream_addr_width_p  inbound address.
- stream_data_i  in  stream_data_width_p  inbound data.
- stream_yumi_o  out  1  inbound word consumed this cycle.
- chan_v_o  out  num_chan_p  one-hot valid to endpoint.
- chan_data_o  out  stream_data_width_p  data to endpoints, shared.
- chan_ready_i  in  num_chan_p  endpoint ready; transfer on chan_v_o[i] & chan_ready_i[i].
- chan_v_i  in  num_chan_p  endpoint outbound valid.
- chan_data_i  in  num_chan_p*stream_data_width_p  endpoint outbound data; channel i at slice i.
- chan_yumi_o  out  num_chan_p  one-hot, endpoint word consumed.
- stream_v_o  out  1  outbound word valid to host.
- stream_data_o  out  stream_data_width_p  outbound data.
- stream_ready_i  in  1  host ready; transfer on stream_v_o & stream_ready_i.
- err_o  out  1  sticky: at least one unmapped write since reset.

## Operation
- Input buffer (ibuf) holds {data, kind, chan_idx}. kind is one of e_chan, e_status, e_drop.
- Decode at capture:
  - address equals a channel address → e_chan with its index;
  - address equals status_addr_p → e_status;
  - otherwise → e_drop.
- stream_yumi_o = stream_v_i & (~ibuf_full | ibuf_deq). The buffer reloads in the same cycle it drains.
- e_chan: chan_v_o[chan_idx]=1 while full. It dequeues on chan_ready_i[chan_idx]. No other chan_v_o bit is ever high.
- e_drop: dequeues the cycle after capture. Increments the drop counter, saturating at all-ones. Sets err_o.
- e_status: waits until the output register can load.
  - Loads the zero-extended counter into the output register and dequeues.
  - Clears the counter in that cycle. If an e_drop would also count that cycle (impossible with one ibuf, but required), the result is 1.
  - The status load has priority over channel words. No chan_yumi_o fires that cycle.
- Outbound path:
  - When the output register can load and no status load is pending, a round-robin arbiter picks among chan_v_i.
  - chan_yumi_o[grant] is asserted and the data is registered.
  - The pointer advances to grant+1 only on a grant. Priority starts at channel 0 after reset.
- Output register loads when empty or when stream_v_o & stream_ready_i. This gives full throughput, one word per cycle.
- Inbound and outbound paths are independent. Status reads are the only coupling.

## Timing
- Reset (reset_i low at posedge) empties ibuf and the output register, clears the counter, err_o and the arbiter pointer.
  - All outputs read 0 in the following cycle: stream_yumi_o, chan_v_o, chan_yumi_o, stream_v_o, err_o.
  - Combinational outputs are gated to 0 while reset_i is low.
- Reset mid-transfer discards buffered words with no handshake.
- Inbound latency:
  - a word accepted in cycle N drives chan_v_o in cycle N+1;
  - a drop counts in N+1;
  - a status read appears on stream_v_o no earlier than N+2.
- Outbound latency: chan_yumi_o in cycle N gives stream_v_o in N+1.
- stream_v_o and stream_data_o are stable while stream_ready_i is low.
- The output register is full and the host is stalled → no chan_yumi_o, and a pending status read blocks ibuf.
- The counter saturates and does not wrap.

## Structure
- bp_stream_pkg holds the ibuf kind enum (e_chan/e_status/e_drop) and the default address constants (nbf 32'h10, mmio 32'h20, status 32'hF0). bp_stream_host re-uses them.
- One sub-module: bp_stream_rr_arb. It is a parametrised num_chan_p round-robin arbiter with grant-enable and pointer-advance-on-grant. It wraps bsg_arb_round_robin if the semantics match.

## Test plan
- Write 0xA5A5_0001 @0x10, then 0xA5A5_0002 @0x20, with both channels ready.
  - chan_v_o = 01 in cycle N+1, then 10 in N+2.
  - Data matches; stream_yumi_o is back-to-back.
- Write @0x14 three times, then read @0xF0.
  - err_o=1; stream_data_o=3.
  - A second @0xF0 read returns 0.
- 65537 unmapped writes, then a status read → 0x0000_FFFF (saturation).
- Both chan_v_i held high with stream_ready_i=1.
  - Grants alternate 0,1,0,1 from reset.
  - Hold stream_ready_i=0 for 5 cycles: no chan_yumi_o, stream_data_o is stable, no word is lost.
- Channel 0 not ready for 4 cycles after a write @0x10.
  - stream_yumi_o=0 on the next inbound word until the drain.
  - Same-cycle reload then occurs.
- Assert reset_i low with both buffers full.
  - All outputs are 0 the next cycle; the counter reads 0 after release.
